// File: rtl/sr_flag_arbiter_if.sv
// ---------------------------------------------------------------------------
// sr_flag_arbiter_if
//   Bundle of request/command inputs and flag/error outputs for the shared
//   SR flag bank.
//
//   Requester side (master drives):
//     REQ   [NREQ]        per-requester request, held until granted
//     S     [NREQ]        per-requester set bit
//     R     [NREQ]        per-requester reset bit
//     IDX   [NREQ*IDXW]   per-requester flag index, field i = IDX[i*IDXW +: IDXW]
//   Bank side (slave drives):
//     GNT     [NREQ]      one-hot grant pulse
//     Q       [NFLAG]     flag bank state
//     Qbar    [NFLAG]     ~Q
//     ERR                 one-cycle illegal-command pulse
//     ERR_ID  [IDW]       requester index of the most recent illegal command
//     ERR_CNT [8]         saturating illegal-command count
// ---------------------------------------------------------------------------
interface sr_flag_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 6,
  parameter int IDXW  = 3
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      REQ;
  logic [NREQ-1:0]      S;
  logic [NREQ-1:0]      R;
  logic [NREQ*IDXW-1:0] IDX;

  logic [NREQ-1:0]      GNT;
  logic [NFLAG-1:0]     Q;
  logic [NFLAG-1:0]     Qbar;
  logic                 ERR;
  logic [IDW-1:0]       ERR_ID;
  logic [7:0]           ERR_CNT;

  modport master (
    output REQ, S, R, IDX,
    input  GNT, Q, Qbar, ERR, ERR_ID, ERR_CNT
  );

  modport slave (
    input  REQ, S, R, IDX,
    output GNT, Q, Qbar, ERR, ERR_ID, ERR_CNT
  );
endinterface

// File: rtl/sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// sr_flag_arbiter
//   Bank of NFLAG SR flags shared by NREQ requesters. A round-robin arbiter
//   picks one requester per clock; its {S,R} command is applied to the flag
//   selected by its IDX field on the same edge that raises its GNT. S=R=1 or
//   an out-of-range index is rejected: no flag changes, ERR pulses, ERR_ID
//   records the requester and ERR_CNT counts up to 255.
//
//   Ports:
//     CLK  clock, all state changes on posedge
//     RST  synchronous active-high reset
//     bus  sr_flag_arbiter_if.slave (REQ/S/R/IDX in; GNT/Q/Qbar/ERR/ERR_ID/
//          ERR_CNT out)
// ---------------------------------------------------------------------------
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 6,
  parameter int IDXW  = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  sr_flag_arbiter_if.slave      bus
);

  localparam int          IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_CLR  = 2'b01,
    CMD_SET  = 2'b10,
    CMD_ILL  = 2'b11
  } cmd_e;

  // Registered state
  logic [IDW-1:0]   r_ptr;
  logic [NREQ-1:0]  r_gnt;
  logic [NFLAG-1:0] r_q;
  logic             r_err;
  logic [IDW-1:0]   r_err_id;
  logic [7:0]       r_err_cnt;

  // Arbitration / decode wires
  logic [NREQ-1:0]  w_elig;
  int unsigned      w_scan;
  logic [IDW-1:0]   w_cand;
  logic             w_found;
  logic [IDW-1:0]   w_win;
  logic [NREQ-1:0]  w_gnt_oh;
  logic [IDW-1:0]   w_ptr_nxt;
  logic             w_s;
  logic             w_r;
  logic [IDXW-1:0]  w_idx;
  cmd_e             w_cmd;
  logic             w_idx_oob;
  logic             w_illegal;
  logic [NFLAG-1:0] w_q_nxt;

  // Last cycle's winner is masked so a single-command requester has one
  // cycle to drop REQ before it could be granted again.
  assign w_elig = bus.REQ & ~r_gnt;

  // Rotating priority scan starting at r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_scan  = 0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      w_scan = 32'(r_ptr) + k;
      if (w_scan >= NREQ_U) begin
        w_scan = w_scan - NREQ_U;
      end
      w_cand = IDW'(w_scan);
      if (!w_found && w_elig[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_gnt_oh        = '0;
    w_gnt_oh[w_win] = 1'b1;
  end

  assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

  // Select the winner's command and index field.
  always_comb begin
    w_s   = 1'b0;
    w_r   = 1'b0;
    w_idx = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (w_win == IDW'(i)) begin
        w_s   = bus.S[i];
        w_r   = bus.R[i];
        w_idx = bus.IDX[i*IDXW +: IDXW];
      end
    end
  end

  assign w_cmd     = cmd_e'({w_s, w_r});
  assign w_idx_oob = ({1'b0, w_idx} >= (IDXW+1)'(NFLAG));
  assign w_illegal = (w_cmd == CMD_ILL) || w_idx_oob;

  // Only the addressed flag may change; illegal commands leave the bank alone.
  always_comb begin
    w_q_nxt = r_q;
    if (w_found && !w_illegal) begin
      for (int unsigned f = 0; f < NFLAG; f++) begin
        if (w_idx == IDXW'(f)) begin
          case (w_cmd)
            CMD_SET: w_q_nxt[f] = 1'b1;
            CMD_CLR: w_q_nxt[f] = 1'b0;
            default: w_q_nxt[f] = r_q[f];
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_q       <= '0;
      r_err     <= 1'b0;
      r_err_id  <= '0;
      r_err_cnt <= '0;
    end else begin
      r_gnt <= '0;
      r_err <= 1'b0;
      if (w_found) begin
        r_gnt <= w_gnt_oh;
        r_ptr <= w_ptr_nxt;
        r_q   <= w_q_nxt;
        if (w_illegal) begin
          r_err    <= 1'b1;
          r_err_id <= w_win;
          if (r_err_cnt != '1) begin
            r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
      end
    end
  end

  assign bus.GNT     = r_gnt;
  assign bus.Q       = r_q;
  assign bus.Qbar    = ~r_q;
  assign bus.ERR     = r_err;
  assign bus.ERR_ID  = r_err_id;
  assign bus.ERR_CNT = r_err_cnt;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sr_flag_arbiter
//   Directed bench for sr_flag_arbiter with NREQ=4, NFLAG=6, IDXW=3.
//   Inputs change 1 time unit after a rising edge; outputs are sampled at
//   the same point, so each check sees the result of the edge just passed.
// ---------------------------------------------------------------------------
module tb_sr_flag_arbiter;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_errors;

  sr_flag_arbiter_if #(.NREQ(4), .NFLAG(6), .IDXW(3)) bus ();

  sr_flag_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idx(input int r, input int v);
    bus.IDX[r*3 +: 3] = 3'(v);
  endtask

  int unsigned exp_cnt;
  int unsigned exp_id;

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Reset with noise on the inputs; no grant may appear.
    RST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.REQ = 4'($urandom);
      bus.S   = 4'($urandom);
      bus.R   = 4'($urandom);
      bus.IDX = 12'($urandom);
      tick();
      check("rst_gnt", 32'(bus.GNT), 32'h0);
      check("rst_q",   32'(bus.Q),   32'h0);
    end
    RST = 1'b0;
    bus.REQ = '0;
    bus.S   = '0;
    bus.R   = '0;
    bus.IDX = '0;
    tick();
    check("rel_q",    32'(bus.Q),       32'h0);
    check("rel_gnt",  32'(bus.GNT),     32'h0);
    check("rel_cnt",  32'(bus.ERR_CNT), 32'h0);
    check("rel_err",  32'(bus.ERR),     32'h0);
    check("rel_id",   32'(bus.ERR_ID),  32'h0);
    check("rel_qbar", 32'(bus.Qbar),    32'h3f);

    // Single set of flag 4 by requester 1 (PTR 0 -> 2).
    bus.REQ = 4'b0010; bus.S = 4'b0010; bus.R = 4'b0000; set_idx(1, 4);
    tick();
    check("set_gnt",  32'(bus.GNT),  32'b0010);
    check("set_q",    32'(bus.Q),    32'b010000);
    check("set_qbar", 32'(bus.Qbar), 32'b101111);
    check("set_err",  32'(bus.ERR),  32'h0);
    bus.REQ = '0;
    tick();
    check("drop_gnt", 32'(bus.GNT), 32'h0);

    // Clear flag 4 by requester 1; scan from 2 wraps back to 1.
    bus.REQ = 4'b0010; bus.S = 4'b0000; bus.R = 4'b0010;
    tick();
    check("clr_gnt", 32'(bus.GNT), 32'b0010);
    check("clr_q",   32'(bus.Q),   32'b000000);
    bus.REQ = '0;
    tick();

    // One-cycle reset to bring PTR back to 0.
    RST = 1'b1;
    tick();
    RST = 1'b0;

    // Round robin: all requesting, requester i sets flag i.
    bus.REQ = 4'b1111; bus.S = 4'b1111; bus.R = 4'b0000;
    for (int i = 0; i < 4; i++) set_idx(i, i);
    tick(); check("rr_gnt0", 32'(bus.GNT), 32'b0001); check("rr_q0", 32'(bus.Q), 32'b000001);
    tick(); check("rr_gnt1", 32'(bus.GNT), 32'b0010); check("rr_q1", 32'(bus.Q), 32'b000011);
    tick(); check("rr_gnt2", 32'(bus.GNT), 32'b0100); check("rr_q2", 32'(bus.Q), 32'b000111);
    tick(); check("rr_gnt3", 32'(bus.GNT), 32'b1000); check("rr_q3", 32'(bus.Q), 32'b001111);
    tick(); check("rr_gnt4", 32'(bus.GNT), 32'b0001); check("rr_q4", 32'(bus.Q), 32'b001111);
    bus.REQ = '0;
    tick();
    check("rr_idle", 32'(bus.GNT), 32'h0);
    // PTR = 1

    // Illegal S=R=1 from requester 2 on flag 0 (currently 1).
    bus.REQ = 4'b0100; bus.S = 4'b0100; bus.R = 4'b0100; set_idx(2, 0);
    tick();
    check("ill_gnt", 32'(bus.GNT),     32'b0100);
    check("ill_err", 32'(bus.ERR),     32'h1);
    check("ill_id",  32'(bus.ERR_ID),  32'd2);
    check("ill_cnt", 32'(bus.ERR_CNT), 32'd1);
    check("ill_q",   32'(bus.Q),       32'b001111);
    bus.REQ = '0;
    tick();
    check("ill_err_drop", 32'(bus.ERR),    32'h0);
    check("ill_id_hold",  32'(bus.ERR_ID), 32'd2);
    // PTR = 3

    // Out-of-range index 7 with a legal set from requester 3.
    bus.REQ = 4'b1000; bus.S = 4'b1000; bus.R = 4'b0000; set_idx(3, 7);
    tick();
    check("oob_gnt", 32'(bus.GNT),     32'b1000);
    check("oob_err", 32'(bus.ERR),     32'h1);
    check("oob_id",  32'(bus.ERR_ID),  32'd3);
    check("oob_cnt", 32'(bus.ERR_CNT), 32'd2);
    check("oob_q",   32'(bus.Q),       32'b001111);
    bus.REQ = '0;
    tick();
    check("oob_err_drop", 32'(bus.ERR), 32'h0);
    // PTR = 0

    // Highest legal index (5) set by requester 0.
    bus.REQ = 4'b0001; bus.S = 4'b0001; bus.R = 4'b0000; set_idx(0, 5);
    tick();
    check("top_gnt", 32'(bus.GNT), 32'b0001);
    check("top_q",   32'(bus.Q),   32'b101111);
    check("top_err", 32'(bus.ERR), 32'h0);
    bus.REQ = '0;
    tick();
    // PTR = 1

    // Hold command consumes a grant without touching the bank.
    bus.REQ = 4'b0010; bus.S = 4'b0000; bus.R = 4'b0000; set_idx(1, 5);
    tick();
    check("hold_gnt", 32'(bus.GNT), 32'b0010);
    check("hold_q",   32'(bus.Q),   32'b101111);
    check("hold_err", 32'(bus.ERR), 32'h0);
    bus.REQ = '0;
    tick();
    // PTR = 2

    // Saturation: requesters 0 and 1 alternate, every grant illegal.
    bus.REQ = 4'b0011; bus.S = 4'b0011; bus.R = 4'b0011;
    exp_cnt = 2;
    exp_id  = 0;
    for (int n = 0; n < 260; n++) begin
      tick();
      if (exp_cnt < 255) exp_cnt++;
      check("sat_err", 32'(bus.ERR),     32'h1);
      check("sat_id",  32'(bus.ERR_ID),  exp_id);
      check("sat_cnt", 32'(bus.ERR_CNT), exp_cnt);
      exp_id = 1 - exp_id;
    end
    bus.REQ = '0;
    tick();
    check("sat_hold", 32'(bus.ERR_CNT), 32'd255);
    check("sat_idle", 32'(bus.ERR),     32'h0);
    check("sat_q",    32'(bus.Q),       32'b101111);
    // PTR = 2

    // Grant requester 0 so PTR = 1 before the mid-operation reset.
    bus.REQ = 4'b0001; bus.S = 4'b0001; bus.R = 4'b0000; set_idx(0, 0);
    tick();
    check("pre_gnt", 32'(bus.GNT), 32'b0001);

    // Reset with requests pending: grant cancelled, PTR back to 0.
    bus.REQ = 4'b0011; bus.S = 4'b0011; bus.R = 4'b0000;
    set_idx(0, 1); set_idx(1, 2);
    RST = 1'b1;
    tick();
    check("mrst_gnt", 32'(bus.GNT),     32'h0);
    check("mrst_q",   32'(bus.Q),       32'h0);
    check("mrst_cnt", 32'(bus.ERR_CNT), 32'h0);
    RST = 1'b0;
    tick();
    check("mrel_gnt0", 32'(bus.GNT), 32'b0001);
    check("mrel_q0",   32'(bus.Q),   32'b000010);
    tick();
    check("mrel_gnt1", 32'(bus.GNT), 32'b0010);
    check("mrel_q1",   32'(bus.Q),   32'b000110);

    // Requester 0 alone holding REQ: granted every other cycle.
    bus.REQ = 4'b0001;
    tick(); check("solo_g0", 32'(bus.GNT), 32'b0001);
    tick(); check("solo_g1", 32'(bus.GNT), 32'b0000);
    tick(); check("solo_g2", 32'(bus.GNT), 32'b0001);
    tick(); check("solo_g3", 32'(bus.GNT), 32'b0000);
    bus.REQ = '0;
    tick();
    check("end_q", 32'(bus.Q), 32'b000110);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
